noc_spike_router: RTL and testbench

Parametrised successor to the spike broadcast bus. Each source node's spike pulses are queued in a per-source saturating event counter. A round-robin arbiter serialises the pending events onto one registered output channel with a valid/ready handshake. Each event is delivered to a programmable destination mask taken from a per-source routing table. The block sits between the neuron-core array and the per-node spike inputs.

---
 rtl/noc_pkg.sv | 32 +++
 rtl/noc_spike_router_rr_arbiter.sv | 36 +++
 rtl/noc_spike_router.sv | 150 +++++++++++++++
 tb/tb_noc_spike_router.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the spike router slice.
// Holds the width-derivation rules for node IDs and per-source event counters,
// plus the power-up routing-table value (every source broadcasts to every node).
package noc_pkg;

    // Smallest w with 2**w >= value (value >= 1).
    function automatic int clog2_int(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Bits needed to name one of num_nodes nodes.
    function automatic int addr_width(input int num_nodes);
        return clog2_int(num_nodes);
    endfunction

    // Bits needed to hold a count from 0 up to queue_depth inclusive.
    function automatic int cnt_width(input int queue_depth);
        return clog2_int(queue_depth + 1);
    endfunction

    localparam int DEF_NUM_NODES   = 4;
    localparam int DEF_QUEUE_DEPTH = 4;

    // Every table bit powers up set, which reproduces the legacy broadcast bus.
    localparam logic TABLE_DEFAULT_BIT = 1'b1;

endpackage

// File: rtl/noc_spike_router_rr_arbiter.sv
// Round-robin arbiter for the spike router.
// Searches the request vector starting at the pointer position and returns the
// first requester found, both as a one-hot grant and as an encoded index.
//   req_i  : one request bit per source
//   ptr_i  : search start position (0 .. NUM_NODES-1)
//   gnt_o  : one-hot grant (all zero when nothing requests)
//   idx_o  : encoded index of the granted source
//   any_o  : at least one request present
module rr_arbiter #(
    parameter int NUM_NODES  = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic [NUM_NODES-1:0]  req_i,
    input  logic [ADDR_WIDTH-1:0] ptr_i,
    output logic [NUM_NODES-1:0]  gnt_o,
    output logic [ADDR_WIDTH-1:0] idx_o,
    output logic                  any_o
);

    always_comb begin : search
        int cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_NODES; k++) begin
            cand = (int'(ptr_i) + k) % NUM_NODES;
            if (!any_o && req_i[cand]) begin
                any_o = 1'b1;
                idx_o = ADDR_WIDTH'(cand);
                gnt_o = NUM_NODES'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/noc_spike_router.sv
// Spike router between the neuron-core array and the per-node spike inputs.
// Each source's spike pulses are counted in a saturating per-source queue
// counter; a round-robin arbiter serialises pending events onto one registered
// output channel (valid/ready), each event carrying its source's routing mask.
//   clk, rst   : clock, asynchronous active-high reset
//   spike_in   : one event per high cycle, per source
//   cfg_we/cfg_addr/cfg_mask : routing-table write port
//   out_ready  : downstream accepts the current event
//   out_valid/out_src/spike_out : current event (spike_out zero when idle)
//   drop_flag  : sticky per-source overflow, cleared by drop_clr
module noc_spike_router
    import noc_pkg::*;
#(
    parameter int NUM_NODES   = DEF_NUM_NODES,
    parameter int ADDR_WIDTH  = addr_width(DEF_NUM_NODES),
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int CNT_WIDTH   = cnt_width(DEF_QUEUE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_NODES-1:0]  spike_in,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [NUM_NODES-1:0]  cfg_mask,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_src,
    output logic [NUM_NODES-1:0]  spike_out,
    output logic [NUM_NODES-1:0]  drop_flag,
    input  logic                  drop_clr
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(QUEUE_DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  count_q [NUM_NODES];
    logic [CNT_WIDTH-1:0]  count_d [NUM_NODES];
    logic [NUM_NODES-1:0]  table_q [NUM_NODES];
    logic [NUM_NODES-1:0]  table_d [NUM_NODES];
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0] out_src_q, out_src_d;
    logic [NUM_NODES-1:0]  spike_out_q, spike_out_d;
    logic [NUM_NODES-1:0]  drop_q, drop_d;

    logic [NUM_NODES-1:0]  req;
    logic [NUM_NODES-1:0]  gnt_raw;
    logic [NUM_NODES-1:0]  gnt;
    logic [ADDR_WIDTH-1:0] win_idx;
    logic                  win_any;
    logic                  grant_ok;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            req[i] = (count_q[i] != '0);
        end
    end

    rr_arbiter #(
        .NUM_NODES  (NUM_NODES),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt_raw),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // The output register may take a new event when empty or being consumed.
    assign grant_ok = !out_valid_q || out_ready;
    assign gnt      = grant_ok ? gnt_raw : '0;

    // Spike and grant on the same source cancel, so a full queue that is being
    // drained can still accept a spike without dropping it.
    always_comb begin
        drop_d = drop_clr ? '0 : drop_q;
        for (int i = 0; i < NUM_NODES; i++) begin
            count_d[i] = count_q[i];
            if (spike_in[i] && !gnt[i]) begin
                if (count_q[i] == DEPTH_C) begin
                    drop_d[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + ONE_C;
                end
            end else if (!spike_in[i] && gnt[i]) begin
                count_d[i] = count_q[i] - ONE_C;
            end
        end
    end

    // The output path reads table_q, so a write to the entry being granted
    // only takes effect from the following grant.
    always_comb begin
        table_d = table_q;
        if (cfg_we && (int'(cfg_addr) < NUM_NODES)) begin
            table_d[cfg_addr] = cfg_mask;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        spike_out_d = spike_out_q;
        ptr_d       = ptr_q;
        if (grant_ok) begin
            if (win_any) begin
                out_valid_d = 1'b1;
                out_src_d   = win_idx;
                spike_out_d = table_q[win_idx];
                ptr_d       = (int'(win_idx) == NUM_NODES - 1) ? '0
                                                               : win_idx + ADDR_WIDTH'(1);
            end else begin
                out_valid_d = 1'b0;
                spike_out_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NODES; i++) begin
                count_q[i] <= '0;
                table_q[i] <= {NUM_NODES{TABLE_DEFAULT_BIT}};
            end
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            spike_out_q <= '0;
            drop_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_NODES; i++) begin
                count_q[i] <= count_d[i];
                table_q[i] <= table_d[i];
            end
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            spike_out_q <= spike_out_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
    assign spike_out = spike_out_q;
    assign drop_flag = drop_q;

endmodule

// File: tb/tb_noc_spike_router.sv
// Self-checking bench for noc_spike_router (4 nodes, queue depth 4).
// Directed scenarios followed by a randomized run, all checked every cycle
// against a behavioural model of queues, table and output channel.
module tb_noc_spike_router;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [3:0] spike_in;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_mask;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] out_src;
    logic [3:0] spike_out;
    logic [3:0] drop_flag;
    logic       drop_clr;

    int tests = 0;
    int fails = 0;

    int         m_cnt [N];
    logic [3:0] m_tbl [N];
    int         m_ptr;
    logic       m_ov;
    int         m_src;
    logic [3:0] m_mask;
    logic [3:0] m_drop;

    noc_spike_router dut (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_mask  (cfg_mask),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_src   (out_src),
        .spike_out (spike_out),
        .drop_flag (drop_flag),
        .drop_clr  (drop_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_tbl[i] = 4'hF;
        end
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_src  = 0;
        m_mask = 4'h0;
        m_drop = 4'h0;
    endtask

    task automatic check_model();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("spike_out", {28'd0, spike_out}, {28'd0, m_mask});
        chk("drop_flag", {28'd0, drop_flag}, {28'd0, m_drop});
        if (m_ov) chk("out_src", {30'd0, out_src}, 32'(m_src));
    endtask

    // One clock: the model applies the queueing/arbitration rules to the
    // inputs present at the edge, then outputs are compared 1 time unit later.
    task automatic cycle();
        int  win;
        int  n;
        bit  gok;
        @(posedge clk);
        gok = !m_ov || out_ready;
        win = -1;
        if (gok) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && m_cnt[(m_ptr + k) % N] > 0) win = (m_ptr + k) % N;
            end
            if (win >= 0) begin
                m_ov   = 1'b1;
                m_src  = win;
                m_mask = m_tbl[win];
                m_ptr  = (win + 1) % N;
            end else begin
                m_ov   = 1'b0;
                m_mask = 4'h0;
            end
        end
        if (drop_clr) m_drop = 4'h0;
        for (int i = 0; i < N; i++) begin
            n = m_cnt[i] + (spike_in[i] ? 1 : 0) - ((i == win) ? 1 : 0);
            if (n > DEPTH) begin
                n = DEPTH;
                m_drop[i] = 1'b1;
            end
            m_cnt[i] = n;
        end
        if (cfg_we) m_tbl[cfg_addr] = cfg_mask;
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        spike_in  = 4'h0;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_mask  = 4'h0;
        drop_clr  = 1'b0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        idle_inputs();
        #1;
        model_reset();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_src", {30'd0, out_src}, 32'd0);
        chk("rst_spike_out", {28'd0, spike_out}, 32'd0);
        chk("rst_drop", {28'd0, drop_flag}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int ev;
        rst       = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        do_reset();
        cycle();

        // 1: single spike on source 2, broadcast mask
        spike_in = 4'b0100;
        cycle();
        chk("t1_latency", {31'd0, out_valid}, 32'd0);
        spike_in = 4'b0000;
        cycle();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_src", {30'd0, out_src}, 32'd2);
        chk("t1_mask", {28'd0, spike_out}, 32'hF);

        // 2: full burst, then a second burst after the pointer wraps
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            spike_in = 4'b1111;
            cycle();
            spike_in = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                cycle();
                chk("t2_valid", {31'd0, out_valid}, 32'd1);
                chk("t2_src", {30'd0, out_src}, 32'(k));
            end
        end
        cycle();
        chk("t2_drain", {31'd0, out_valid}, 32'd0);

        // 3: table write, then write colliding with a grant of the same entry
        do_reset();
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mask = 4'b0101;
        cycle();
        cfg_we = 1'b0;
        spike_in = 4'b0010;
        cycle();
        spike_in = 4'b0000;
        cycle();
        chk("t3_mask", {28'd0, spike_out}, 32'h5);
        spike_in = 4'b0010;
        cycle();
        spike_in = 4'b0000;
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_mask = 4'b0011;
        cycle();
        chk("t3_old_mask", {28'd0, spike_out}, 32'h5);
        cfg_we = 1'b0;
        spike_in = 4'b0010;
        cycle();
        spike_in = 4'b0000;
        cycle();
        chk("t3_new_mask", {28'd0, spike_out}, 32'h3);

        // 4: back-pressure, saturation, drop, drain and clear
        do_reset();
        out_ready = 1'b0;
        spike_in  = 4'b1000;
        for (int k = 0; k < 6; k++) cycle();
        chk("t4_held_src", {30'd0, out_src}, 32'd3);
        chk("t4_drop", {28'd0, drop_flag}, 32'h8);
        spike_in  = 4'b0000;
        out_ready = 1'b1;
        ev = out_valid ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (out_valid) ev++;
        end
        chk("t4_events", 32'(ev), 32'd5);
        drop_clr = 1'b1;
        cycle();
        drop_clr = 1'b0;
        chk("t4_clr", {28'd0, drop_flag}, 32'h0);

        // 5: full queue with spike and grant together
        do_reset();
        out_ready = 1'b0;
        spike_in  = 4'b0001;
        for (int k = 0; k < 5; k++) cycle();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        chk("t5_no_drop", {28'd0, drop_flag}, 32'h0);
        spike_in = 4'b0000;
        ev = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (out_valid) ev++;
        end
        chk("t5_events", 32'(ev), 32'd4);

        // 6: reset with events pending and the output occupied
        do_reset();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_mask = 4'b0001;
        cycle();
        cfg_we    = 1'b0;
        out_ready = 1'b0;
        spike_in  = 4'b1111;
        for (int k = 0; k < 3; k++) cycle();
        spike_in = 4'b0000;
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
        end
        spike_in = 4'b0100;
        cycle();
        spike_in = 4'b0000;
        cycle();
        chk("t6_table_reset", {28'd0, spike_out}, 32'hF);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            spike_in  = 4'($urandom) & 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_addr  = 2'($urandom);
            cfg_mask  = 4'($urandom);
            drop_clr  = ($urandom_range(0, 15) == 0);
            cycle();
        end
        idle_inputs();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
